// File: rtl/inst_fetch_mem.sv
// Loadable instruction memory with a one-cycle registered fetch port, stall/flush control,
// out-of-range detection and optional stored parity (enable with `define INST_MEM_PARITY_EN).
module inst_fetch_mem #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] address,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] instruction,
  output logic              inst_valid,
  output logic              addr_err,
  output logic              parity_err
);

  localparam int              IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic {EMPTY, HOLDING} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    written;
  logic                accept;
  logic                fetch_in_range;
  logic                load_in_range;
  logic                load_write;
  logic                bypass;
  logic [IDX_W-1:0]    fetch_idx;
  logic [IDX_W-1:0]    load_idx;
  logic [DATA_W-1:0]   read_word;

  assign fetch_idx      = address[IDX_W-1:0];
  assign load_idx       = load_addr[IDX_W-1:0];
  assign fetch_in_range = {1'b0, address} < DEPTH_X;
  assign load_in_range  = {1'b0, load_addr} < DEPTH_X;
  assign load_write     = load_en && load_in_range;
  assign accept         = fetch_req && !stall && !flush;
  assign bypass         = load_write && (load_idx == fetch_idx);

  // The word array is deliberately left without reset; the written flags gate its contents.
  always_ff @(posedge clk) begin
    if (load_write) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written <= '0;
    end else if (load_write) begin
      written[load_idx] <= 1'b1;
    end
  end

  // Write-first: a same-cycle load to the fetched index is forwarded straight through.
  always_comb begin
    read_word = NOP_WORD;
    if (fetch_in_range) begin
      if (bypass) begin
        read_word = load_data;
      end else if (written[fetch_idx]) begin
        read_word = mem[fetch_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else if (!stall) begin
      state_next = accept ? HOLDING : EMPTY;
    end
  end

  always_comb begin
    inst_valid = (state == HOLDING);
  end

  // Error flags qualify the current result, so they clear whenever the result is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_WORD;
      addr_err    <= 1'b0;
    end else if (flush) begin
      addr_err <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        instruction <= read_word;
        addr_err    <= !fetch_in_range;
      end else begin
        addr_err <= 1'b0;
      end
    end
  end

`ifdef INST_MEM_PARITY_EN
  logic             par_mem [DEPTH];
  logic             parity_bad;
  logic             parity_q;

  always_ff @(posedge clk) begin
    if (load_write) begin
      par_mem[load_idx] <= ^load_data;
    end
  end

  // Only words actually read from the array are checked; forwarded load data is trusted.
  always_comb begin
    parity_bad = 1'b0;
    if (fetch_in_range && !bypass && written[fetch_idx]) begin
      parity_bad = (^mem[fetch_idx]) != par_mem[fetch_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (flush) begin
      parity_q <= 1'b0;
    end else if (!stall) begin
      parity_q <= accept ? parity_bad : 1'b0;
    end
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Scoreboard bench for inst_fetch_mem: a reference model pushes expected outputs per driven
// cycle, popped and compared one edge later.
module tb_inst_fetch_mem;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0;
`ifdef INST_MEM_PARITY_EN
  localparam bit          PAR   = 1'b1;
`else
  localparam bit          PAR   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, stall, flush, load_en;
  logic [31:0] address, load_addr, load_data;
  logic [31:0] instruction;
  logic        inst_valid, addr_err, parity_err;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        aerr;
    logic        perr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_mem [DEPTH];
  logic [DEPTH-1:0] m_flag, m_bad;
  logic [31:0] m_instr;
  logic        m_valid, m_aerr, m_perr;
  int          n_checks = 0;
  int          n_fail   = 0;

  inst_fetch_mem #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .address(address), .stall(stall),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instruction(instruction), .inst_valid(inst_valid), .addr_err(addr_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare one edge later.
  task automatic applyStimulus(input logic fr, input logic [31:0] a, input logic st, input logic fl,
                               input logic le, input logic [31:0] la, input logic [31:0] ld);
    exp_t e;
    fetch_req = fr; address = a; stall = st; flush = fl;
    load_en = le; load_addr = la; load_data = ld;
    if (fl) begin
      m_valid = 0; m_aerr = 0; m_perr = 0;
    end else if (!st) begin
      if (fr) begin
        m_valid = 1;
        m_perr  = 0;
        if (a >= DEPTH) begin
          m_instr = NOP; m_aerr = 1;
        end else begin
          m_aerr = 0;
          if (le && la == a) m_instr = ld;
          else if (m_flag[a[7:0]]) begin
            m_instr = m_mem[a[7:0]];
            m_perr  = PAR && m_bad[a[7:0]];
          end else m_instr = NOP;
        end
      end else begin
        m_valid = 0; m_aerr = 0; m_perr = 0;
      end
    end
    if (le && la < DEPTH) begin
      m_mem[la[7:0]] = ld; m_flag[la[7:0]] = 1'b1; m_bad[la[7:0]] = 1'b0;
    end
    e.instr = m_instr; e.valid = m_valid; e.aerr = m_aerr; e.perr = m_perr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checkOutput("instruction", instruction, e.instr);
    checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, e.valid});
    checkOutput("addr_err", {31'b0, addr_err}, {31'b0, e.aerr});
    checkOutput("parity_err", {31'b0, parity_err}, {31'b0, e.perr});
  endtask

  task automatic fetch(input logic [31:0] a);
    applyStimulus(1, a, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [31:0] la, input logic [31:0] ld);
    applyStimulus(0, 0, 0, 0, 1, la, ld);
  endtask

  // Reset acts immediately, so outputs are checked before any clock edge.
  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_instruction", instruction, NOP);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_addr_err", {31'b0, addr_err}, 32'd0);
    checkOutput("rst_parity_err", {31'b0, parity_err}, 32'd0);
    m_flag = '0; m_bad = '0; m_instr = NOP; m_valid = 0; m_aerr = 0; m_perr = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t, expected under 500000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fetch_req = 0; address = 0; stall = 0; flush = 0;
    load_en = 0; load_addr = 0; load_data = 0;
    rst = 0;
    #2;
    doReset();

    fetch(0);
    load(0, 32'h1); load(1, 32'h2); load(2, 32'h3);
    fetch(0); fetch(1); fetch(2);
    fetch(DEPTH); fetch(0);
    fetch(DEPTH - 1);

    fetch(1);
    repeat (3) applyStimulus(1, 2, 1, 0, 0, 0, 0);
    fetch(2);
    applyStimulus(1, 2, 1, 1, 0, 0, 0);
    fetch(1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    fetch(0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 5, 0, 0, 1, 5, 32'hDEADBEEF);
    fetch(5);
    applyStimulus(1, 2, 0, 0, 1, 1, 32'h77);
    fetch(1);
    load(300, 32'h12345678);
    fetch(300);
    load(DEPTH - 1, 32'hCAFEF00D);
    fetch(DEPTH - 1);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 9) == 0) ? 32'(DEPTH) : 32'($urandom_range(0, 9)),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1, 32'($urandom_range(0, 9)), $urandom);
    end

    fetch(5);
    doReset();
    fetch(5);

`ifdef INST_MEM_PARITY_EN
    load(3, 32'hA5A5A5A5);
    load(4, 32'h0000000F);
    dut.mem[3][0] = ~dut.mem[3][0];
    m_mem[3][0] = ~m_mem[3][0];
    m_bad[3] = 1'b1;
    fetch(3);
    applyStimulus(1, 4, 1, 0, 0, 0, 0);
    fetch(4);
    fetch(3);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
`endif

    if (sb_q.size() != 0) checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_mem.md
# inst_fetch_mem

Parametrised, synchronous instruction memory for the pipeline's fetch stage. It replaces the fixed combinational program ROM with a loadable word array, a one-cycle registered read port with a fetch handshake, stall/flush control from the hazard unit, and out-of-range detection. Unwritten or out-of-range words return a configurable NOP, so the decode stage always sees a legal encoding.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits
- DEPTH, 256, number of instruction words (≥2)
- ADDR_W, 32, width of ADDRESS / LOAD_ADDR (word index, not byte address)
- NOP_WORD, 0, word returned for unwritten or out-of-range fetches

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- FETCH_REQ  in  1  fetch strobe; ADDRESS sampled when high and accepted
- ADDRESS  in  ADDR_W  word index of the instruction to fetch
- STALL  in  1  hold current output registers
- FLUSH  in  1  invalidate current output and drop same-cycle request
- LOAD_EN  in  1  program-load write strobe
- LOAD_ADDR  in  ADDR_W  word index to write
- LOAD_DATA  in  DATA_W  instruction word to write
- INSTRUCTION  out  DATA_W  fetched instruction (registered)
- INST_VALID  out  1  INSTRUCTION holds an accepted fetch result
- ADDR_ERR  out  1  accepted fetch had ADDRESS ≥ DEPTH
- PARITY_ERR  out  1  stored parity mismatch on fetched word (INST_MEM_PARITY_EN only)

## Operation
- Storage: DEPTH × DATA_W array plus a DEPTH-bit written-flag vector. The array is not reset. The flag vector is cleared by RST.
- Load: when LOAD_EN is high and LOAD_ADDR < DEPTH, the word and its flag are written at the clock edge. If LOAD_ADDR ≥ DEPTH, the write is ignored silently.
- Fetch acceptance: a request is accepted when FETCH_REQ=1, STALL=0 and FLUSH=0.
- Accepted fetch result:
  - ADDRESS ≥ DEPTH: INSTRUCTION=NOP_WORD, ADDR_ERR=1, INST_VALID=1.
  - Flag clear: INSTRUCTION=NOP_WORD, ADDR_ERR=0, INST_VALID=1.
  - Otherwise: stored word, ADDR_ERR=0, INST_VALID=1.
- Idle: FETCH_REQ=0 with no stall or flush gives INST_VALID=0 next cycle. INSTRUCTION keeps its last value.
- Control priority: RST > FLUSH > STALL > FETCH_REQ.
  - FLUSH: INST_VALID=0 and ADDR_ERR=0 next cycle. INSTRUCTION is unchanged.
  - STALL: all outputs hold. FETCH_REQ is ignored; upstream must keep ADDRESS until STALL drops.
- Read/write collision: LOAD_EN and an accepted fetch in the same cycle to the same in-range index return LOAD_DATA (write-first bypass) with the flag treated as set.
- Fetch and load are independent ports; both may act every cycle.
- States per cycle, derived from INST_VALID: EMPTY (INST_VALID=0) and HOLDING (INST_VALID=1).
  - EMPTY→HOLDING on an accepted fetch.
  - HOLDING→EMPTY on FLUSH, or on an idle cycle without STALL.
  - HOLDING→HOLDING on STALL, or on an accepted fetch.

## Timing
- Reset values (asynchronous, immediate): INSTRUCTION=NOP_WORD, INST_VALID=0, ADDR_ERR=0, PARITY_ERR=0, all written flags=0.
- Read latency: one cycle. ADDRESS accepted at edge N is reflected on the outputs after edge N.
- Throughput: one fetch per cycle, back-to-back, no bubbles.
- Load-to-fetch:
  - A load at edge N is visible to a fetch accepted at edge N (bypass) or later.
  - A fetch accepted before edge N returns the old contents.
- STALL/FLUSH act on the same edge they are sampled.
- RST asserted mid-stream: outputs go to reset values immediately. Loaded programs become unreadable (NOP) until reloaded.
- Deasserting RST takes effect at the next rising edge; RST must be released synchronously by the reset generator.

## Configuration
- Macro: INST_MEM_PARITY_EN.
- Defined:
  - Each load stores an extra even-parity bit over LOAD_DATA.
  - Each accepted in-range, written fetch recomputes parity. PARITY_ERR=1 for that result on mismatch and holds/clears with INST_VALID under STALL/FLUSH.
  - The bypass path never flags an error.
- Undefined: no parity storage; PARITY_ERR is tied to 0.

## Test plan
- Reset then fetch ADDRESS=0 → after one edge INSTRUCTION=NOP_WORD (0), INST_VALID=1, ADDR_ERR=0.
- Load 0x00000001@0, 0x00000002@1, 0x00000003@2; fetch 0,1,2 back-to-back → INSTRUCTION 1,2,3 on consecutive cycles, INST_VALID constantly 1.
- Fetch ADDRESS=DEPTH (256) → INSTRUCTION=0, ADDR_ERR=1. Next fetch of 0 → ADDR_ERR=0.
- Fetch 1, then STALL for 3 cycles while ADDRESS=2 → INSTRUCTION holds 0x2 for 3 cycles, then shows 0x3 one cycle after STALL drops. Repeat with STALL and FLUSH together → INST_VALID=0.
- Same cycle LOAD_EN@5 with 0xDEADBEEF and fetch 5 → INSTRUCTION=0xDEADBEEF. Assert RST, release, fetch 5 → INSTRUCTION=0.
- INST_MEM_PARITY_EN: load 0xA5A5A5A5@3, force-flip stored bit 0 via hierarchical write, fetch 3 → PARITY_ERR=1. Fetch a clean word → PARITY_ERR=0.
